// File: rtl/mux_pipeline_serializer.sv
// ---------------------------------------------------------------------------
// mux_pipeline_serializer
//
// Captures one wide vector of NUM_IN lanes. It then emits the vector as a
// sequence of LANES_OUT-lane beats, with valid/ready handshakes on both sides.
// The vector's mode is sampled when the vector is accepted:
//   - cfg_beats sets the beat count N. A value of 0, or any value greater
//     than BEATS, selects all BEATS groups.
//   - cfg_rev selects descending group order.
// Within a beat, the lowest-numbered lane of the group is placed in the MSB
// byte. This matches the legacy pipeline mux.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   input vector valid
//   in_ready   block can accept a vector this cycle
//   in_data    NUM_IN lanes, lane i at [i*DATA_W +: DATA_W]
//   cfg_beats  beats to emit for the vector being accepted
//   cfg_rev    1 = descending group order for the vector being accepted
//   out_valid  output beat valid
//   out_ready  downstream accepts the beat
//   out_data   current beat (LANES_OUT lanes)
//   out_beat   group index carried by the current beat
//   out_last   current beat is the final beat of its vector
// ---------------------------------------------------------------------------
module mux_pipeline_serializer #(
    parameter  int DATA_W    = 8,
    parameter  int NUM_IN    = 16,
    parameter  int LANES_OUT = 4,
    localparam int BEATS     = NUM_IN / LANES_OUT,
    localparam int BW        = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_IN*DATA_W-1:0]    in_data,
    input  logic [BW:0]                 cfg_beats,
    input  logic                        cfg_rev,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES_OUT*DATA_W-1:0] out_data,
    output logic [BW-1:0]               out_beat,
    output logic                        out_last
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [BW-1:0] LAST_G   = BW'(BEATS - 1);
    localparam logic [BW:0]   BEATS_CT = (BW + 1)'(BEATS);

    // Extract group g from a vector, lowest lane of the group in the MSB slot.
    function automatic logic [LANES_OUT*DATA_W-1:0] pack_group(
        input logic [NUM_IN*DATA_W-1:0] vec,
        input logic [BW-1:0]            g
    );
        logic [LANES_OUT*DATA_W-1:0] r;
        r = '0;
        for (int j = 0; j < LANES_OUT; j++) begin
            r[(LANES_OUT-1-j)*DATA_W +: DATA_W] =
                vec[(int'(g)*LANES_OUT + j)*DATA_W +: DATA_W];
        end
        return r;
    endfunction

    state_t                      state_q;
    logic [NUM_IN*DATA_W-1:0]    vec_q;
    logic                        rev_q;
    logic [BW:0]                 n_q;
    logic [BW-1:0]               k_q;
    logic                        out_valid_q;
    logic [LANES_OUT*DATA_W-1:0] out_data_q;
    logic [BW-1:0]               out_beat_q;
    logic                        out_last_q;

    logic                        accept_d;
    logic [BW:0]                 n_d;
    logic [BW-1:0]               first_grp_d;
    logic [BW-1:0]               k_next_d;
    logic [BW-1:0]               grp_next_d;
    logic                        last_next_d;

    // A new vector can enter while idle, or while the final beat of the
    // current vector is completing. This gives back-to-back vectors with no
    // idle bubble between them.
    always_comb begin
        in_ready = rst_n && ((state_q == IDLE) || (out_last_q && out_ready));
        accept_d = in_valid && in_ready;

        if ((cfg_beats == '0) || (cfg_beats > BEATS_CT)) begin
            n_d = BEATS_CT;
        end else begin
            n_d = cfg_beats;
        end
        first_grp_d = cfg_rev ? LAST_G : '0;

        k_next_d    = k_q + 1'b1;
        grp_next_d  = rev_q ? (LAST_G - k_next_d) : k_next_d;
        last_next_d = ({1'b0, k_next_d} == (n_q - 1'b1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_beat_q  <= '0;
            out_last_q  <= 1'b0;
        end else if (accept_d) begin
            // Beat 0 is built straight from in_data into the output register.
            // The output stays registered, so out_data sees no combinational
            // path from in_data.
            state_q     <= SEND;
            vec_q       <= in_data;
            rev_q       <= cfg_rev;
            n_q         <= n_d;
            k_q         <= '0;
            out_valid_q <= 1'b1;
            out_data_q  <= pack_group(in_data, first_grp_d);
            out_beat_q  <= first_grp_d;
            out_last_q  <= (n_d == (BW + 1)'(1));
        end else if ((state_q == SEND) && out_ready) begin
            if (out_last_q) begin
                state_q     <= IDLE;
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end else begin
                k_q        <= k_next_d;
                out_data_q <= pack_group(vec_q, grp_next_d);
                out_beat_q <= grp_next_d;
                out_last_q <= last_next_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_beat  = out_beat_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_mux_pipeline_serializer.sv
// ---------------------------------------------------------------------------
// tb_mux_pipeline_serializer
//
// Directed and randomized stimulus for mux_pipeline_serializer with default
// parameters. The bench keeps a reference model as a queue of the beats still
// owed downstream. An accepted vector appends its N beats to the queue, each
// computed directly from the lane/group rules. A completed beat pops the
// queue.
// ---------------------------------------------------------------------------
module tb_mux_pipeline_serializer;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [2:0]   cfg_beats;
    logic         cfg_rev;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic [1:0]   out_beat;
    logic         out_last;

    mux_pipeline_serializer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .cfg_beats (cfg_beats),
        .cfg_rev   (cfg_rev),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_beat  (out_beat),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  b;
        logic        l;
    } beat_t;

    beat_t q[$];
    int    checks   = 0;
    int    failures = 0;
    logic  accepted;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mkvec(input logic [7:0] base);
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[i*8 +: 8] = base + 8'(i);
        return v;
    endfunction

    // Reference: N beats from cfg_beats, group order from cfg_rev, lane g*4+j
    // packed at byte position 3-j of the 32-bit word.
    task automatic push_vec(input logic [127:0] v, input logic [2:0] cb, input logic rv);
        int    n;
        int    g;
        beat_t e;
        n = (cb == 0 || cb > 4) ? 4 : int'(cb);
        for (int k = 0; k < n; k++) begin
            g   = rv ? (3 - k) : k;
            e.d = 32'h0;
            for (int j = 0; j < 4; j++) e.d = (e.d << 8) | 32'(v[(g*4 + j)*8 +: 8]);
            e.b = 2'(g);
            e.l = (k == n - 1);
            q.push_back(e);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check the
    // settled outputs, then advance the model to match the coming rising edge.
    task automatic cyc(input logic r, input logic iv, input logic [127:0] v,
                       input logic [2:0] cb, input logic rv, input logic ordy);
        logic exp_rdy;
        @(negedge clk);
        rst_n     = r;
        in_valid  = iv;
        in_data   = v;
        cfg_beats = cb;
        cfg_rev   = rv;
        out_ready = ordy;
        #1;
        exp_rdy = r && ((q.size() == 0) || (q.size() == 1 && ordy));
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chk("out_data", 64'(out_data), 64'(q[0].d));
            chk("out_beat", 64'(out_beat), 64'(q[0].b));
            chk("out_last", 64'(out_last), 64'(q[0].l));
        end
        accepted = iv && exp_rdy;
        if (!r) begin
            q.delete();
        end else begin
            if (q.size() != 0 && ordy) void'(q.pop_front());
            if (accepted) push_vec(v, cb, rv);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() != 0; i++) cyc(1, 0, '0, 0, 0, 1);
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    logic [127:0] va, vb, vr;
    logic [31:0]  fwd [4];
    logic [1:0]   ordy_pat [4];

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        cfg_beats = '0;
        cfg_rev   = 1'b0;
        out_ready = 1'b0;
        va  = mkvec(8'h10);
        vb  = mkvec(8'h20);
        fwd = '{32'h10111213, 32'h14151617, 32'h18191A1B, 32'h1C1D1E1F};
        ordy_pat = '{2'd1, 2'd0, 2'd0, 2'd1};

        // Reset state
        cyc(0, 1, va, 0, 0, 1);
        cyc(0, 1, va, 0, 0, 1);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_beat", 64'(out_beat), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        cyc(1, 0, '0, 0, 0, 1);

        // Forward, all beats
        cyc(1, 1, va, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, '0, 0, 0, 1);
            chk("tp_fwd_data", 64'(out_data), 64'(fwd[i]));
            chk("tp_fwd_last", 64'(out_last), 64'(i == 3));
        end
        cyc(1, 0, '0, 0, 0, 1);

        // Reverse, all beats
        cyc(1, 1, va, 0, 1, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, '0, 0, 0, 1);
            chk("tp_rev_data", 64'(out_data), 64'(fwd[3 - i]));
            chk("tp_rev_beat", 64'(out_beat), 64'(3 - i));
        end
        drain();

        // Short vector, oversized count, single beat
        cyc(1, 1, va, 2, 0, 1);
        drain();
        cyc(1, 1, va, 7, 0, 1);
        drain();
        for (int i = 0; i < 4; i++) cyc(1, 1, mkvec(8'(8'h40 + 8'(i) * 8'h10)), 1, 0, 1);
        drain();

        // Back-to-back A then B with in_valid held high
        cyc(1, 1, va, 0, 0, 1);
        for (int i = 0; i < 8 && !accepted; i++) cyc(1, 1, vb, 0, 0, 1);
        chk("b2b_accept", 64'(accepted), 64'd1);
        for (int i = 0; i < 4; i++) cyc(1, 0, '0, 0, 0, 1);
        drain();

        // Stall pattern 1,0,0,1 with two vectors queued
        cyc(1, 1, va, 0, 0, 1);
        for (int i = 0; i < 24; i++) cyc(1, 1, vb, 0, 1, ordy_pat[i % 4][0]);
        drain();

        // Reset during beat 1
        cyc(1, 1, va, 0, 0, 1);
        cyc(1, 0, '0, 0, 0, 1);
        cyc(0, 0, '0, 0, 0, 1);
        cyc(1, 0, '0, 0, 0, 1);
        chk("midrst_data", 64'(out_data), 64'd0);
        cyc(1, 1, va, 0, 0, 1);
        cyc(1, 0, '0, 0, 0, 0);
        chk("post_rst_data", 64'(out_data), 64'h10111213);
        chk("post_rst_beat", 64'(out_beat), 64'd0);
        drain();

        // Randomized traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            vr = {$urandom, $urandom, $urandom, $urandom};
            cyc(($urandom_range(0, 49) != 0), 1'($urandom), vr,
                3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom));
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_pipeline_serializer.md
Name: mux_pipeline_serializer

Overview:
Parametrised, pipelined successor to the fixed 16-byte to 32-bit pipeline mux. It captures one wide vector of NUM_IN lanes and emits it as LANES_OUT-lane beats over several cycles. A per-vector mode selects beat count and beat order, and valid/ready handshakes on both sides provide backpressure. It sits between the line-buffer/PE array and the 32-bit pipeline datapath of the fused block.

Parameters:
DATA_W, 8, bits per lane
NUM_IN, 16, input lanes per vector; must be a multiple of LANES_OUT
LANES_OUT, 4, lanes per output beat
BEATS, NUM_IN/LANES_OUT (derived, localparam), maximum beats per vector
BW, $clog2(BEATS) with a minimum of 1 (derived), beat index width

Ports:
clk  in  1  single clock; all logic on the rising edge
rst_n  in  1  synchronous, active-low reset
in_valid  in  1  input vector valid
in_ready  out  1  block can accept a vector this cycle
in_data  in  NUM_IN*DATA_W  lane i at bits [i*DATA_W +: DATA_W]
cfg_beats  in  BW+1  beats to emit for this vector; sampled on input acceptance
cfg_rev  in  1  1 = emit groups in descending order; sampled on input acceptance
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts beat
out_data  out  LANES_OUT*DATA_W  current beat
out_beat  out  BW  group index of the current beat
out_last  out  1  current beat is the final beat of its vector

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; out_valid=0, out_data=0, out_beat=0, out_last=0, internal beat counter=0. in_ready=0 while rst_n=0 and returns high the cycle after release. Reset mid-vector discards the vector; no partial beats are emitted after reset.
- Input accepted when in_valid && in_ready. On acceptance the block latches in_data, cfg_rev and the effective beat count N:
  - N = BEATS when cfg_beats==0 or cfg_beats>BEATS
  - otherwise N = cfg_beats
- Group selection:
  - cfg_rev=0: beat k (0..N-1) carries group g=k.
  - cfg_rev=1: beat k carries group g=BEATS-1-k.
- Packing, matching the existing pipeline mux byte order: out_data[LANES_OUT*DATA_W-1 -: DATA_W] = lane g*LANES_OUT+0, down to the LSB lane g*LANES_OUT+LANES_OUT-1. out_beat=g.
- Latency: a vector accepted at edge T presents its first beat (out_valid=1) from T+1. Output is fully registered; there is no combinational path from in_data to out_data.
- Output handshake: a beat completes when out_valid && out_ready. While out_valid=1 && out_ready=0, out_data/out_beat/out_last hold stable.
- out_last=1 exactly on beat N-1.
- FSM:
  - IDLE: in_ready=1, out_valid=0. Acceptance -> SEND with beat 0 loaded.
  - SEND: out_valid=1.
    - Non-last beat completes -> next beat loaded next cycle.
    - Last beat completes with no new vector -> IDLE.
  - in_ready in SEND = out_last && out_ready (combinational).
  - Last beat completing while a new vector is accepted in the same cycle -> stay in SEND; the new vector's beat 0 appears on the next cycle. This gives zero bubble between vectors.
- Full throughput: N cycles per vector when out_ready is held at 1.
- cfg_beats/cfg_rev changes outside acceptance cycles have no effect on the vector in flight.
- N=1: the single beat has out_last=1. With out_ready=1, in_ready stays high continuously, giving one vector per cycle.

Test Plan:
- Default params; lane i = 8'h10+i; cfg_beats=0, cfg_rev=0, out_ready=1 -> beats 32'h10111213, 32'h14151617, 32'h18191A1B, 32'h1C1D1E1F; out_beat 0,1,2,3; out_last on beat 3 only; first beat one cycle after acceptance.
- Same vector, cfg_rev=1 -> 32'h1C1D1E1F (beat idx 3), 32'h18191A1B, 32'h14151617, 32'h10111213 (idx 0, out_last=1).
- cfg_beats=2, cfg_rev=0 -> exactly 32'h10111213, 32'h14151617 with out_last on the second; cfg_beats=7 -> behaves as 4 beats.
- Back-to-back vectors A (lanes 8'h10+i) and B (lanes 8'h20+i), in_valid held high, out_ready=1 -> 8 consecutive valid beats with no gap; in_ready high only in the A-last-beat cycle.
- out_ready toggled 1,0,0,1,... -> each beat held stable while stalled; no beat lost or duplicated; in_ready=0 throughout except on accepted last beats.
- Assert rst_n=0 for one cycle during beat 1 of a vector -> next cycle out_valid=0, out_data=0; idle with in_ready=1 after release; the next vector starts at beat 0 with correct data.
